// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// State encoding, reset PC default, instruction width, branch decision.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        FU_RST   = 2'd0,
        FU_FETCH = 2'd1,
        FU_EXEC  = 2'd2
    } fu_state_t;

    localparam logic [31:0] FU_RESET_PC = 32'h0000_0000;
    localparam int          INSTR_W     = 32;

    // A jump always redirects; a branch only when the ALU saw equality.
    function automatic logic take_f(
        input logic jump,
        input logic branch,
        input logic zero
    );
        return jump | (branch & zero);
    endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// Next-PC calculation: sequential PC+4 or PC+4 plus a signed word offset.
// Purely combinational; wraps modulo 2^32.
module fetch_next_pc
    import fetch_unit_pkg::*;
(
    input  logic [31:0] PC,
    input  logic [7:0]  OFFSET,
    input  logic        JUMP,
    input  logic        BRANCH,
    input  logic        ZERO,
    output logic [31:0] NEXT_PC
);

    logic        take;
    logic [31:0] seq_pc;
    logic [31:0] disp;

    assign take    = take_f(JUMP, BRANCH, ZERO);
    assign seq_pc  = PC + 32'd4;
    // Word offset sign-extended and scaled to bytes.
    assign disp    = {{22{OFFSET[7]}}, OFFSET, 2'b00};
    assign NEXT_PC = take ? seq_pc + disp : seq_pc;

endmodule

// File: rtl/fetch_unit.sv
// Registered fetch stage: PC, imem handshake, instruction latch,
// and a saturating counter of busywait-stalled cycles.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = FU_RESET_PC,
    parameter int          STALL_CNT_W = 16
) (
    input  logic                   CLK,
    input  logic                   RESET_N,
    input  logic                   JUMP,
    input  logic                   BRANCH,
    input  logic                   ZERO,
    input  logic [7:0]             OFFSET,
    input  logic                   DATA_BUSYWAIT,
    input  logic                   INSTR_BUSYWAIT,
    input  logic [INSTR_W-1:0]     INSTR_READDATA,
    output logic                   INSTR_READ,
    output logic [31:0]            INSTR_ADDRESS,
    output logic [31:0]            PC,
    output logic [INSTR_W-1:0]     INSTRUCTION,
    output logic                   INSTR_VALID,
    output logic [STALL_CNT_W-1:0] STALL_CYCLES
);

    fu_state_t              state;
    logic [31:0]            pc_q;
    logic [31:0]            next_pc;
    logic [INSTR_W-1:0]     instr_q;
    logic [STALL_CNT_W-1:0] stall_q;
    logic [STALL_CNT_W-1:0] stall_inc;
    logic                   read_q;
    logic                   valid_q;

    fetch_next_pc u_next_pc (
        .PC      (pc_q),
        .OFFSET  (OFFSET),
        .JUMP    (JUMP),
        .BRANCH  (BRANCH),
        .ZERO    (ZERO),
        .NEXT_PC (next_pc)
    );

    // Counter holds at all-ones instead of wrapping.
    assign stall_inc = (&stall_q) ? stall_q : stall_q + 1'b1;

    // FSM with PC, instruction latch, stall counter and registered strobes.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state   <= FU_RST;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            stall_q <= '0;
            read_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            unique case (state)
                FU_RST: begin
                    state  <= FU_FETCH;
                    read_q <= 1'b1;
                end
                FU_FETCH: begin
                    if (INSTR_BUSYWAIT) begin
                        stall_q <= stall_inc;
                    end else begin
                        instr_q <= INSTR_READDATA;
                        state   <= FU_EXEC;
                        read_q  <= 1'b0;
                        valid_q <= 1'b1;
                    end
                end
                FU_EXEC: begin
                    if (DATA_BUSYWAIT) begin
                        stall_q <= stall_inc;
                    end else begin
                        pc_q    <= next_pc;
                        state   <= FU_FETCH;
                        read_q  <= 1'b1;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state   <= FU_RST;
                    read_q  <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign INSTR_READ    = read_q;
    assign INSTR_VALID   = valid_q;
    assign INSTR_ADDRESS = pc_q;
    assign PC            = pc_q;
    assign INSTRUCTION   = instr_q;
    assign STALL_CYCLES  = stall_q;

endmodule
